// File: rtl/weight_loader_if.sv
// Bus bundle for weight_loader: the load handshake, the weight-memory read port and the
// register-file write port.
//   master : the loader (drives mem_rd_en/mem_addr, rf_clr, w_en/w_1/w_2, busy, done)
//   slave  : the controller/memory/register-file side
// Optional feature macro: WLOAD_STALL_EN adds mem_stall (shared-memory read back-pressure).
interface weight_loader_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_rdata;
    logic              rf_clr;
    logic              w_en;
    logic [WIDTH-1:0]  w_1;
    logic [WIDTH-1:0]  w_2;
    logic              busy;
    logic              done;
`ifdef WLOAD_STALL_EN
    logic              mem_stall;
`endif

    modport master (
        input  start, base_addr, mem_rdata,
`ifdef WLOAD_STALL_EN
        input  mem_stall,
`endif
        output mem_rd_en, mem_addr, rf_clr, w_en, w_1, w_2, busy, done
    );

    modport slave (
        output start, base_addr, mem_rdata,
`ifdef WLOAD_STALL_EN
        output mem_stall,
`endif
        input  mem_rd_en, mem_addr, rf_clr, w_en, w_1, w_2, busy, done
    );
endinterface

// File: rtl/weight_loader.sv
// weight_loader: fetches one kernel of N_TAP signed weights from weight memory, highest tap
// first, and streams it two taps per w_en pulse into the downstream weight register file.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous reset, active high
//   bus_io : weight_loader_if.master (start/base_addr in, memory read port, rf_clr,
//            w_en/w_1/w_2 pair output, busy, done)
// Optional feature macro: WLOAD_STALL_EN -- honours mem_stall while issuing reads.
module weight_loader #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N_TAP  = 31,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input logic             clk_i,
    input logic             rst_i,
    weight_loader_if.master bus_io
);
    localparam int unsigned       CntW   = $clog2(N_TAP + 1);
    localparam logic [CntW-1:0]   NTapC  = CntW'(N_TAP);
    localparam logic [ADDR_W-1:0] TopOff = ADDR_W'(N_TAP - 1);

    typedef enum logic [2:0] {StIdle, StClear, StRead, StDrain, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CntW-1:0]   iss_q;      // reads issued so far in this load
    logic [CntW-1:0]   ret_q;      // words returned so far (index j of the next return)
    logic [RD_LAT-1:0] vld_q;      // marks cycles on which mem_rdata is valid
    logic [WIDTH-1:0]  pend_q;     // even-j word waiting for its lower partner
    logic [WIDTH-1:0]  w_1_q;
    logic [WIDTH-1:0]  w_2_q;
    logic              rd_q;       // high for the whole READ state
    logic              clr_q;
    logic              w_en_q;
    logic              busy_q;
    logic              done_q;

    logic stall;
    logic rd_fire;
    logic ret_vld;
    logic ret_last;

`ifdef WLOAD_STALL_EN
    assign stall = bus_io.mem_stall;
`else
    assign stall = 1'b0;
`endif

    // rd_q is only set in READ, so gating it here confines the stall to READ.
    assign rd_fire  = rd_q & ~stall;
    assign ret_vld  = vld_q[RD_LAT-1];
    assign ret_last = (ret_q == NTapC - 1'b1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
            vld_q   <= '0;
            pend_q  <= '0;
            w_1_q   <= '0;
            w_2_q   <= '0;
            rd_q    <= 1'b0;
            clr_q   <= 1'b0;
            w_en_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            clr_q  <= 1'b0;
            w_en_q <= 1'b0;
            done_q <= 1'b0;

            vld_q[0] <= rd_fire;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end

            // Pair packing runs on returns regardless of state, so it overlaps READ.
            if (ret_vld) begin
                ret_q <= ret_q + 1'b1;
                if (ret_q[0]) begin
                    w_en_q <= 1'b1;
                    w_2_q  <= pend_q;
                    w_1_q  <= bus_io.mem_rdata;
                end else if (ret_last) begin
                    // Odd N_TAP: the final word (tap 0) goes out alone.
                    w_en_q <= 1'b1;
                    w_2_q  <= bus_io.mem_rdata;
                    w_1_q  <= '0;
                end else begin
                    pend_q <= bus_io.mem_rdata;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        state_q <= StClear;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        addr_q  <= bus_io.base_addr + TopOff;
                        iss_q   <= '0;
                        ret_q   <= '0;
                    end
                end
                StClear: begin
                    state_q <= StRead;
                    rd_q    <= 1'b1;
                end
                StRead: begin
                    if (!stall) begin
                        iss_q <= iss_q + 1'b1;
                        if (iss_q == NTapC - 1'b1) begin
                            rd_q    <= 1'b0;
                            state_q <= StDrain;
                        end else begin
                            addr_q <= addr_q - 1'b1;
                        end
                    end
                end
                StDrain: begin
                    // Once every word is back, the w_en now on the bus is the last one.
                    if (w_en_q && (ret_q == NTapC)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.mem_rd_en = rd_fire;
    assign bus_io.mem_addr  = addr_q;
    assign bus_io.rf_clr    = clr_q;
    assign bus_io.w_en      = w_en_q;
    assign bus_io.w_1       = w_1_q;
    assign bus_io.w_2       = w_2_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.done      = done_q;
endmodule
